// File: rtl/wb_host_pkg.sv
// Shared types and defaults for the Wishbone classic host master and its timeout helper.
package wb_host_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    localparam int                DEF_TIMEOUT_CYCLES = 255;
    localparam logic [DAT_W-1:0]  DEF_ERR_DATA       = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_host_timeout.sv
// Saturating wait counter for an outstanding strobe; flags expiry once the count reaches TIMEOUT_CYCLES.
module wb_host_timeout
    import wb_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNT_MAX);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone B4 classic initiator: one command in, one bus cycle, one response out.
// Optional strobe timeout enabled by defining WB_HOST_TIMEOUT_EN.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int               TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [DAT_W-1:0] ERR_DATA       = DEF_ERR_DATA
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [DAT_W-1:0] wbm_dat_i
);

    state_t state, state_nx;
    logic   accept;
    logic   done_ack;
    logic   done_tmo;

    // Gated by reset so the command port reads not-ready while reset is held.
    assign cmd_ready = (state == IDLE) && !wb_rst_i;
    assign accept    = cmd_valid && cmd_ready;
    assign done_ack  = (state == BUS) && wbm_ack_i;

`ifdef WB_HOST_TIMEOUT_EN
    logic tmo_expired;

    wb_host_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (accept),
        .inc     ((state == BUS) && !wbm_ack_i),
        .expired (tmo_expired)
    );

    // An ACK arriving on the expiry edge takes priority over the timeout.
    assign done_tmo = (state == BUS) && tmo_expired && !wbm_ack_i;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign done_tmo       = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)                state_nx = BUS;
            BUS:     if (done_ack || done_tmo)  state_nx = RESP;
            RESP:    if (rsp_ready)             state_nx = IDLE;
            default:                            state_nx = IDLE;
        endcase
    end

    // Outputs follow the next state so CYC/STB and rsp_valid change on the same edge as the state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            wbm_cyc_o <= (state_nx == BUS);
            wbm_stb_o <= (state_nx == BUS);
            rsp_valid <= (state_nx == RESP);
            if (accept) begin
                wbm_we_o  <= cmd_we;
                wbm_sel_o <= cmd_sel;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
            end
            if (done_ack) begin
                rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
                rsp_err <= 1'b0;
            end else if (done_tmo) begin
                rsp_dat <= ERR_DATA;
                rsp_err <= 1'b1;
            end
        end
    end

endmodule
